flow_status_monitor: RTL and testbench

Per-FIFO occupancy and status generator for the five data FIFOs (MF, VC0, VC1, D0, D1). It consumes the packed threshold word `umbrales_I` and the per-FIFO push/pop strobes. It produces the `FIFO_error` and `FIFO_empty` vectors read by `fsmControl`, plus almost-full and almost-empty flags for the flow-control logic. It is the producer side of the status/threshold interface that the control FSM consumes.

---
 rtl/fifo_ctrl_pkg.sv | 33 +++
 rtl/fifo_level_counter.sv | 77 +++++++
 rtl/flow_status_monitor.sv | 85 ++++++++
 tb/tb_flow_status_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared FIFO indices, depth defaults and threshold field layout
//
// Purpose: constants shared by the FIFO status monitor and its per-FIFO counters.
// Bit order of every 5-bit status vector: [4]=MF, [3]=VC0, [2]=VC1, [1]=D0, [0]=D1.
package fifo_ctrl_pkg;

    localparam int N_FIFO = 5;

    localparam int IDX_MF  = 4;
    localparam int IDX_VC0 = 3;
    localparam int IDX_VC1 = 2;
    localparam int IDX_D0  = 1;
    localparam int IDX_D1  = 0;

    localparam int DEPTH_MF_DEF = 4;
    localparam int DEPTH_VC_DEF = 16;
    localparam int DEPTH_D_DEF  = 4;

    localparam int UMB_W = 14;

    // Margin field offset/width inside umbrales_I
    localparam int OFF_MF  = 12;
    localparam int W_MF    = 2;
    localparam int OFF_VC0 = 8;
    localparam int W_VC0   = 4;
    localparam int OFF_VC1 = 4;
    localparam int W_VC1   = 4;
    localparam int OFF_D0  = 2;
    localparam int W_D0    = 2;
    localparam int OFF_D1  = 0;
    localparam int W_D1    = 2;

endpackage

// File: rtl/fifo_level_counter.sv
// rtl/fifo_level_counter.sv - occupancy counter with sticky error and level flags for one FIFO
//
// Purpose: tracks one FIFO's word count (0..DEPTH) from push/pop strobes and
// produces registered status flags computed from the post-update count.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, pop         one-word write/read strobes
//   margin            threshold margin already selected for this edge
//   err_clear         clears the sticky error bit (a new error the same cycle wins)
//   error             sticky overflow/underflow flag
//   empty             count == 0
//   almost_full       count >= DEPTH - margin
//   almost_empty      count <= margin
module fifo_level_counter
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [MW-1:0] margin,
    input  logic          err_clear,
    output logic          error,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          err_set;
    logic [CW-1:0] margin_ext;
    logic [CW-1:0] full_level;

    // Margin is narrower than the counter, so DEPTH - margin never wraps.
    assign margin_ext = CW'(margin);
    assign full_level = DEPTH_C - margin_ext;

    always_comb begin
        count_d = count_q;
        err_set = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == DEPTH_C) err_set = 1'b1;
                else                    count_d = count_q + 1'b1;
            end
            2'b01: begin
                if (count_q == '0) err_set = 1'b1;
                else               count_d = count_q - 1'b1;
            end
            default: ;  // idle or simultaneous push+pop: count holds, even at 0 or DEPTH
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            error        <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count_q      <= count_d;
            error        <= err_set | (error & ~err_clear);
            empty        <= (count_d == '0);
            almost_full  <= (count_d >= full_level);
            almost_empty <= (count_d <= margin_ext);
        end
    end

endmodule

// File: rtl/flow_status_monitor.sv
// rtl/flow_status_monitor.sv - occupancy/status generator for the MF, VC0, VC1, D0, D1 FIFOs
//
// Purpose: holds the active threshold word and instantiates one level counter per FIFO.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   umbrales_I     packed margins {MF[13:12], VC0[11:8], VC1[7:4], D0[3:2], D1[1:0]}
//   umbral_load    captures umbrales_I into the threshold register
//   push, pop      per-FIFO strobes
//   err_clear      clears all sticky error bits
//   FIFO_error     sticky overflow/underflow flags
//   FIFO_empty     count == 0
//   almost_full    count >= DEPTH - margin
//   almost_empty   count <= margin
module flow_status_monitor
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH_MF = DEPTH_MF_DEF,
    parameter int DEPTH_VC = DEPTH_VC_DEF,
    parameter int DEPTH_D  = DEPTH_D_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [UMB_W-1:0] umbrales_I,
    input  logic             umbral_load,
    input  logic [4:0]       push,
    input  logic [4:0]       pop,
    input  logic             err_clear,
    output logic [4:0]       FIFO_error,
    output logic [4:0]       FIFO_empty,
    output logic [4:0]       almost_full,
    output logic [4:0]       almost_empty
);

    logic [UMB_W-1:0] umb_q;
    logic [UMB_W-1:0] umb_d;

    // Counters see the post-load thresholds so a load takes effect on the same edge.
    assign umb_d = umbral_load ? umbrales_I : umb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) umb_q <= '0;
        else       umb_q <= umb_d;
    end

    fifo_level_counter #(.DEPTH(DEPTH_MF), .MW(W_MF)) u_mf (
        .clk(clk), .reset(reset),
        .push(push[IDX_MF]), .pop(pop[IDX_MF]),
        .margin(umb_d[OFF_MF +: W_MF]), .err_clear(err_clear),
        .error(FIFO_error[IDX_MF]), .empty(FIFO_empty[IDX_MF]),
        .almost_full(almost_full[IDX_MF]), .almost_empty(almost_empty[IDX_MF])
    );

    fifo_level_counter #(.DEPTH(DEPTH_VC), .MW(W_VC0)) u_vc0 (
        .clk(clk), .reset(reset),
        .push(push[IDX_VC0]), .pop(pop[IDX_VC0]),
        .margin(umb_d[OFF_VC0 +: W_VC0]), .err_clear(err_clear),
        .error(FIFO_error[IDX_VC0]), .empty(FIFO_empty[IDX_VC0]),
        .almost_full(almost_full[IDX_VC0]), .almost_empty(almost_empty[IDX_VC0])
    );

    fifo_level_counter #(.DEPTH(DEPTH_VC), .MW(W_VC1)) u_vc1 (
        .clk(clk), .reset(reset),
        .push(push[IDX_VC1]), .pop(pop[IDX_VC1]),
        .margin(umb_d[OFF_VC1 +: W_VC1]), .err_clear(err_clear),
        .error(FIFO_error[IDX_VC1]), .empty(FIFO_empty[IDX_VC1]),
        .almost_full(almost_full[IDX_VC1]), .almost_empty(almost_empty[IDX_VC1])
    );

    fifo_level_counter #(.DEPTH(DEPTH_D), .MW(W_D0)) u_d0 (
        .clk(clk), .reset(reset),
        .push(push[IDX_D0]), .pop(pop[IDX_D0]),
        .margin(umb_d[OFF_D0 +: W_D0]), .err_clear(err_clear),
        .error(FIFO_error[IDX_D0]), .empty(FIFO_empty[IDX_D0]),
        .almost_full(almost_full[IDX_D0]), .almost_empty(almost_empty[IDX_D0])
    );

    fifo_level_counter #(.DEPTH(DEPTH_D), .MW(W_D1)) u_d1 (
        .clk(clk), .reset(reset),
        .push(push[IDX_D1]), .pop(pop[IDX_D1]),
        .margin(umb_d[OFF_D1 +: W_D1]), .err_clear(err_clear),
        .error(FIFO_error[IDX_D1]), .empty(FIFO_empty[IDX_D1]),
        .almost_full(almost_full[IDX_D1]), .almost_empty(almost_empty[IDX_D1])
    );

endmodule

// File: tb/tb_flow_status_monitor.sv
// tb/tb_flow_status_monitor.sv - self-checking bench for flow_status_monitor
module tb_flow_status_monitor;

    logic        clk;
    logic        reset;
    logic [13:0] umbrales_I;
    logic        umbral_load;
    logic [4:0]  push;
    logic [4:0]  pop;
    logic        err_clear;
    logic [4:0]  FIFO_error;
    logic [4:0]  FIFO_empty;
    logic [4:0]  almost_full;
    logic [4:0]  almost_empty;

    flow_status_monitor dut (
        .clk(clk), .reset(reset),
        .umbrales_I(umbrales_I), .umbral_load(umbral_load),
        .push(push), .pop(pop), .err_clear(err_clear),
        .FIFO_error(FIFO_error), .FIFO_empty(FIFO_empty),
        .almost_full(almost_full), .almost_empty(almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] err;
        logic [4:0] emp;
        logic [4:0] af;
        logic [4:0] ae;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model state, index = FIFO bit position
    int   m_cnt [5];
    bit   m_err [5];
    int   m_marg[5];
    int   m_dep [5] = '{4, 4, 16, 16, 4};  // [0]=D1 [1]=D0 [2]=VC1 [3]=VC0 [4]=MF

    exp_t last;

    function automatic int field_of(input int i, input logic [13:0] um);
        case (i)
            4:       return int'(um[13:12]);
            3:       return int'(um[11:8]);
            2:       return int'(um[7:4]);
            1:       return int'(um[3:2]);
            default: return int'(um[1:0]);
        endcase
    endfunction

    function automatic exp_t model_flags();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            e.err[i] = m_err[i];
            e.emp[i] = (m_cnt[i] == 0);
            e.af[i]  = (m_cnt[i] >= m_dep[i] - m_marg[i]);
            e.ae[i]  = (m_cnt[i] <= m_marg[i]);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_cnt[i]  = 0;
            m_err[i]  = 1'b0;
            m_marg[i] = 0;
        end
        sb.delete();
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        push        = '0;
        pop         = '0;
        umbral_load = 1'b0;
        umbrales_I  = '0;
        err_clear   = 1'b0;
    endtask

    // Called at a negedge: drive one cycle of stimulus, predict, then compare after the edge.
    task automatic apply(input string tag, input logic [4:0] pu, input logic [4:0] po,
                         input logic ld, input logic [13:0] um, input logic clr);
        exp_t e;
        bit   ev;
        push = pu; pop = po; umbral_load = ld; umbrales_I = um; err_clear = clr;
        if (ld)
            for (int i = 0; i < 5; i++) m_marg[i] = field_of(i, um);
        for (int i = 0; i < 5; i++) begin
            ev = 1'b0;
            if (pu[i] && !po[i]) begin
                if (m_cnt[i] == m_dep[i]) ev = 1'b1;
                else                      m_cnt[i]++;
            end else if (po[i] && !pu[i]) begin
                if (m_cnt[i] == 0) ev = 1'b1;
                else               m_cnt[i]--;
            end
            m_err[i] = ev | (m_err[i] & !clr);
        end
        sb.push_back(model_flags());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        last = e;
        chk({tag, ".err"}, FIFO_error,   e.err);
        chk({tag, ".emp"}, FIFO_empty,   e.emp);
        chk({tag, ".af"},  almost_full,  e.af);
        chk({tag, ".ae"},  almost_empty, e.ae);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".err"}, FIFO_error,   5'b00000);
        chk({tag, ".emp"}, FIFO_empty,   5'b11111);
        chk({tag, ".af"},  almost_full,  5'b00000);
        chk({tag, ".ae"},  almost_empty, 5'b11111);
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // Reset values, before any clock edge
        reset = 1'b1;
        #2;
        chk_reset_vals("rst_async");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) apply("idle", '0, '0, 1'b0, '0, 1'b0);
        chk_reset_vals("rst_idle");

        // VC0 fill with margin 4
        apply("ld_vc0", '0, '0, 1'b1, 14'h0400, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            apply("vc0_push", 5'b01000, '0, 1'b0, '0, 1'b0);
            if (k == 1)  chk("vc0_empty_fall", {4'b0, FIFO_empty[3]},   5'd0);
            if (k == 4)  chk("vc0_ae_at4",     {4'b0, almost_empty[3]}, 5'd1);
            if (k == 5)  chk("vc0_ae_at5",     {4'b0, almost_empty[3]}, 5'd0);
            if (k == 11) chk("vc0_af_at11",    {4'b0, almost_full[3]},  5'd0);
            if (k == 12) chk("vc0_af_at12",    {4'b0, almost_full[3]},  5'd1);
        end

        // VC0 overflow then drain
        apply("vc0_ovf", 5'b01000, '0, 1'b0, '0, 1'b0);
        chk("vc0_ovf_err", FIFO_error, 5'b01000);
        for (int k = 1; k <= 16; k++) begin
            apply("vc0_pop", '0, 5'b01000, 1'b0, '0, 1'b0);
            if (k == 15) chk("vc0_not_empty15", {4'b0, FIFO_empty[3]}, 5'd0);
        end
        chk("vc0_drained_empty", {4'b0, FIFO_empty[3]}, 5'd1);
        chk("vc0_err_sticky",    {4'b0, FIFO_error[3]}, 5'd1);

        // MF underflow and clear
        apply("clr0", '0, '0, 1'b0, '0, 1'b1);
        apply("mf_unf", '0, 5'b10000, 1'b0, '0, 1'b0);
        chk("mf_unf_err", FIFO_error, 5'b10000);
        apply("mf_clr", '0, '0, 1'b0, '0, 1'b1);
        chk("mf_clr_err", FIFO_error, 5'b00000);

        // Full boundary on D0, set-wins on D1
        for (int k = 0; k < 4; k++) apply("d_fill", 5'b00011, '0, 1'b0, '0, 1'b0);
        apply("d_bound", 5'b00011, 5'b00010, 1'b0, '0, 1'b1);
        chk("d_bound_err", FIFO_error, 5'b00001);
        chk("d0_still_full", {4'b0, almost_full[1]}, 5'd1);
        for (int k = 1; k <= 4; k++) begin
            apply("d0_pop", '0, 5'b00010, 1'b0, '0, 1'b0);
            if (k == 3) chk("d0_not_empty3", {4'b0, FIFO_empty[1]}, 5'd0);
        end
        chk("d0_empty4", {4'b0, FIFO_empty[1]}, 5'd1);
        chk("d0_no_err", {4'b0, FIFO_error[1]}, 5'd0);

        // Load concurrent with push: new margin applies on the same edge
        apply("vc1_ld_push", 5'b00100, '0, 1'b1, 14'h00F0, 1'b0);
        chk("vc1_af_same_edge", {4'b0, almost_full[2]}, 5'd1);

        // Random traffic against the model
        for (int k = 0; k < 60; k++) begin
            logic [4:0]  rp, ro;
            logic [13:0] ru;
            rp = 5'($urandom);
            ro = 5'($urandom);
            ru = 14'($urandom);
            apply("rand", rp, ro, ($urandom_range(0, 7) == 0), ru, ($urandom_range(0, 9) == 0));
        end

        // Mid-operation reset
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) apply("mf_fill3", 5'b10000, '0, 1'b0, '0, 1'b0);
        apply("vc1_unf", '0, 5'b00100, 1'b0, '0, 1'b0);
        chk("pre_rst_err", FIFO_error, 5'b00100);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_midop");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        apply("mf_first", 5'b10000, '0, 1'b0, '0, 1'b0);
        chk("mf_first_ae", {4'b0, almost_empty[4]}, 5'd0);
        for (int k = 2; k <= 4; k++) begin
            apply("mf_refill", 5'b10000, '0, 1'b0, '0, 1'b0);
            if (k == 3) chk("mf_af_at3", {4'b0, almost_full[4]}, 5'd0);
        end
        chk("mf_af_at4", {4'b0, almost_full[4]}, 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
